banner_sequencer: RTL and testbench

//  End-of-game banner controller for the VGA sprite path. On a game-won or game-lost event it

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 34 +++
 rtl/banner_sequencer.sv | 163 ++++++++++++++++
 tb/tb_banner_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite/banner path.
package sprite_pkg;

  // Screen geometry in pixels.
  localparam int SCREEN_HEIGHT = 480;
  localparam int SCREEN_WIDTH  = 640;

  // Width of sprite origin coordinates.
  localparam int ROW_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    SCROLL,
    HOLD,
    BLINK,
    DONE
  } banner_state_t;

  typedef enum logic {
    BANNER_WIN,
    BANNER_LOSE
  } banner_sel_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running motion-tick prescaler: counts 0..TICK_DIV-1 while enabled and
// raises tick for the single cycle in which the count sits at TICK_DIV-1.
// clr restarts the count so the first tick after a clear is TICK_DIV cycles away.
module tick_prescaler #(
  parameter int TICK_DIV = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Cycle counter: clear wins over counting, wraps after the tick cycle.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/banner_sequencer.sv
// End-of-game banner controller: on win/lose it scrolls the banner up from
// below the screen, holds it, blinks it, then leaves it shown until restart.
module banner_sequencer
  import sprite_pkg::*;
#(
  parameter int TICK_DIV    = 2_000_000,
  parameter int STEP        = 3,
  parameter int START_ROW   = SCREEN_HEIGHT,
  parameter int TARGET_ROW  = 150,
  parameter int COLUMN      = 195,
  parameter int HOLD_TICKS  = 32,
  parameter int BLINK_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_won,
  input  logic             game_lost,
  input  logic             restart,
  output logic [ROW_W-1:0] sprite_row,
  output logic [ROW_W-1:0] sprite_column,
  output logic             banner_sel,
  output logic             banner_en,
  output logic             busy,
  output logic             done
);

  localparam logic [ROW_W-1:0] START_V  = ROW_W'(START_ROW);
  localparam logic [ROW_W-1:0] TARGET_V = ROW_W'(TARGET_ROW);
  localparam logic [ROW_W-1:0] STEP_V   = ROW_W'(STEP);
  // One extra bit so TARGET_ROW+STEP cannot wrap in the comparison.
  localparam logic [ROW_W:0]   SUB_MIN  = (ROW_W + 1)'(TARGET_ROW + STEP);

  localparam int PHASE_MAX = (HOLD_TICKS > BLINK_TICKS) ? HOLD_TICKS : BLINK_TICKS;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(HOLD_TICKS - 1);
  localparam logic [PHASE_W-1:0] BLINK_LAST = PHASE_W'(BLINK_TICKS - 1);

  banner_state_t      state_q, state_d;
  banner_sel_t        sel_q, sel_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick;
  logic               tick_run;
  logic               tick_clr;

  // Ticks only run while the banner is in motion; every state change restarts them.
  assign tick_run = state_q inside {SCROLL, HOLD, BLINK};
  assign tick_clr = (state_d != state_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_run),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Next-state and next-output logic; restart overrides everything.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    sel_d   = sel_q;
    row_d   = row_q;
    phase_d = phase_q;
    en_d    = en_q;

    if (restart) begin
      state_d = IDLE;
      sel_d   = BANNER_WIN;
      row_d   = START_V;
      phase_d = '0;
      en_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (game_won || game_lost) begin
            state_d = SCROLL;
            sel_d   = game_won ? BANNER_WIN : BANNER_LOSE;
            en_d    = 1'b1;
          end
        end
        SCROLL: begin
          if (tick) begin
            // Compare before subtracting so the row never passes the target.
            if ({1'b0, row_q} >= SUB_MIN) begin
              row_d = row_q - STEP_V;
            end else begin
              row_d   = TARGET_V;
              state_d = HOLD;
              phase_d = '0;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (phase_q == HOLD_LAST) begin
              state_d = BLINK;
              phase_d = '0;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        BLINK: begin
          if (tick) begin
            if (phase_q == BLINK_LAST) begin
              state_d = DONE;
              phase_d = '0;
              en_d    = 1'b1;
            end else begin
              phase_d = phase_q + 1'b1;
              en_d    = ~en_q;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = state_d inside {SCROLL, HOLD, BLINK};
    done_d = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= BANNER_WIN;
      row_q   <= START_V;
      phase_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sprite_row    = row_q;
  assign sprite_column = ROW_W'(COLUMN);
  assign banner_sel    = sel_q;
  assign banner_en     = en_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_banner_sequencer.sv
// Bench for banner_sequencer: two instances (STEP=4 and STEP=3) share stimulus
// and are checked every cycle against a timeline model of the banner sequence.
module tb_banner_sequencer;

  localparam int D      = 4;
  localparam int H      = 3;
  localparam int B      = 4;
  localparam int S_A    = 4;
  localparam int S_B    = 3;
  localparam int START  = 480;
  localparam int TARGET = 150;
  localparam int COL    = 195;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_won;
  logic        game_lost;
  logic        restart;
  logic [11:0] a_row, a_col, b_row, b_col;
  logic        a_sel, a_en, a_busy, a_done;
  logic        b_sel, b_en, b_busy, b_done;

  int checks   = 0;
  int failures = 0;

  // Model: whether a sequence is running, cycles since it began, latched banner.
  bit active = 1'b0;
  int cyc    = 0;
  int sel_m  = 0;

  typedef struct {
    int row;
    int en;
    int busy;
    int done;
    int sel;
  } exp_t;

  always #5 clk = ~clk;

  banner_sequencer #(
    .TICK_DIV (D), .STEP (S_A), .HOLD_TICKS (H), .BLINK_TICKS (B)
  ) dut_a (
    .clk (clk), .rst (rst_n), .game_won (game_won), .game_lost (game_lost),
    .restart (restart), .sprite_row (a_row), .sprite_column (a_col),
    .banner_sel (a_sel), .banner_en (a_en), .busy (a_busy), .done (a_done)
  );

  banner_sequencer #(
    .TICK_DIV (D), .STEP (S_B), .HOLD_TICKS (H), .BLINK_TICKS (B)
  ) dut_b (
    .clk (clk), .rst (rst_n), .game_won (game_won), .game_lost (game_lost),
    .restart (restart), .sprite_row (b_row), .sprite_column (b_col),
    .banner_sel (b_sel), .banner_en (b_en), .busy (b_busy), .done (b_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Expected outputs from elapsed ticks since trigger: the row falls by s per tick
  // until the next step would pass the target, one more tick lands on the target,
  // then H hold ticks, B blink ticks (visible on even offsets), then done.
  function automatic exp_t model_out(input int s);
    exp_t e;
    int   n;
    int   j;
    int   blink0;
    e = '{row: START, en: 0, busy: 0, done: 0, sel: 0};
    if (active) begin
      n      = (START - TARGET) / s;
      j      = cyc / D;
      blink0 = n + 1 + H;
      e.sel  = sel_m;
      e.en   = 1;
      e.busy = 1;
      e.row  = (j <= n) ? START - j * s : TARGET;
      if (j >= blink0 && j < blink0 + B) e.en = ((j - blink0) % 2 == 0) ? 1 : 0;
      if (j >= blink0 + B) begin
        e.busy = 0;
        e.done = 1;
      end
    end
    return e;
  endfunction

  task automatic compare_all();
    exp_t ea;
    exp_t eb;
    ea = model_out(S_A);
    eb = model_out(S_B);
    check("a_row",  a_row,  ea.row);
    check("a_col",  a_col,  COL);
    check("a_sel",  a_sel,  ea.sel);
    check("a_en",   a_en,   ea.en);
    check("a_busy", a_busy, ea.busy);
    check("a_done", a_done, ea.done);
    check("b_row",  b_row,  eb.row);
    check("b_col",  b_col,  COL);
    check("b_sel",  b_sel,  eb.sel);
    check("b_en",   b_en,   eb.en);
    check("b_busy", b_busy, eb.busy);
    check("b_done", b_done, eb.done);
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare.
  task automatic step();
    @(posedge clk);
    if (!rst_n || restart) begin
      active = 1'b0;
    end else if (!active) begin
      if (game_won || game_lost) begin
        active = 1'b1;
        cyc    = 0;
        sel_m  = game_won ? 0 : 1;
      end
    end else begin
      cyc++;
    end
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  int  len;
  bit  rr;

  initial begin
    rst_n     = 1'b0;
    game_won  = 1'b0;
    game_lost = 1'b0;
    restart   = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(3);

    // Won pulse: full sequence, then DONE held well beyond 1000 cycles.
    game_won = 1'b1;
    step();
    game_won = 1'b0;
    run(1500);
    do_restart();

    // Won and lost together selects the winner; lost during HOLD is ignored.
    game_won  = 1'b1;
    game_lost = 1'b1;
    step();
    game_won  = 1'b0;
    game_lost = 1'b0;
    run(340);
    game_lost = 1'b1;
    run(3);
    game_lost = 1'b0;
    run(200);
    do_restart();

    // Lost held as a level: loser banner, then re-arms right after restart.
    game_lost = 1'b1;
    run(600);
    do_restart();
    run(10);
    game_lost = 1'b0;
    run(20);
    do_restart();

    // Restart while the STEP=4 banner is blanked mid-blink; restart beats won in IDLE.
    game_lost = 1'b1;
    step();
    game_lost = 1'b0;
    run(348);
    restart  = 1'b1;
    game_won = 1'b1;
    run(2);
    restart  = 1'b0;
    game_won = 1'b0;
    run(3);

    // Asynchronous reset mid-scroll, asserted between clock edges.
    game_won = 1'b1;
    step();
    game_won = 1'b0;
    run(50);
    rst_n = 1'b0;
    #1;
    active = 1'b0;
    compare_all();
    #2;
    rst_n = 1'b1;
    run(5);

    // Random episodes: sparse win/lose pulses, optional sparse restarts.
    for (int ep = 0; ep < 30; ep++) begin
      len = $urandom_range(700, 20);
      rr  = 1'($urandom_range(1, 0));
      for (int k = 0; k < len; k++) begin
        game_won  = ($urandom_range(15, 0) == 0);
        game_lost = ($urandom_range(15, 0) == 0);
        restart   = rr && ($urandom_range(99, 0) == 0);
        step();
      end
      game_won  = 1'b0;
      game_lost = 1'b0;
      do_restart();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
